// File: rtl/adder_tree_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_acc_if
// Brief    : Input-beat and result-stream handshake bundle for adder_tree_acc.
// Revision : 1.0
// ============================================================================
interface adder_tree_acc_if #(
    parameter int BITS = 16,
    parameter int NUM  = 4
);
    logic                valid;
    logic                ready;
    logic [NUM*BITS-1:0] data_in;
    logic                last;
    logic                acc_mode;
    logic [BITS-1:0]     o;
    logic                ovf;
    logic                valid_out;
    logic                ready_out;

    // Producer/consumer side of the block.
    modport master (
        output valid, data_in, last, acc_mode, ready_out,
        input  ready, o, ovf, valid_out
    );

    // The adder tree itself.
    modport slave (
        input  valid, data_in, last, acc_mode, ready_out,
        output ready, o, ovf, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/adder_tree_acc.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_acc
// Brief    : Pipelined NUM-channel unsigned adder tree with valid/ready stall,
//            multi-beat accumulate and sticky overflow. Define ADDER_SAT_EN to
//            saturate results instead of wrapping.
// Revision : 1.0
// ============================================================================
module adder_tree_acc #(
    parameter int BITS = 16,
    parameter int NUM  = 4
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    adder_tree_acc_if.slave  bus
);
    localparam int LVL = $clog2(NUM);
    localparam int W   = BITS + LVL;
    localparam logic [W:0] MAX_SUM = (W+1)'({BITS{1'b1}});

    logic             adv;
    logic [LVL:0]     tv;
    logic [LVL:0]     tl;
    logic [LVL:0]     tm;
    logic [W-1:0]     nxt  [0:LVL][0:NUM-1];
    logic [W-1:0]     node [0:LVL][0:NUM-1];

    logic [BITS-1:0]  acc;
    logic             ovf_st;
    logic [BITS-1:0]  o_r;
    logic             ovf_r;
    logic             valid_out_r;

    logic [BITS-1:0]  base;
    logic [W:0]       sum;
    logic             over;
    logic             ovf_new;
    logic             emit;
    logic [BITS-1:0]  res;

    // A full output register that is not being drained freezes the whole pipe.
    assign adv           = !valid_out_r || bus.ready_out;
    assign bus.ready     = adv;
    assign bus.o         = o_r;
    assign bus.ovf       = ovf_r;
    assign bus.valid_out = valid_out_r;

    // Level 0 captures the channels; each later level pairs up the previous one.
    generate
        for (genvar l = 0; l <= LVL; l++) begin : g_lvl
            for (genvar j = 0; j < NUM; j++) begin : g_ch
                if (l == 0) begin : g_in
                    assign nxt[l][j] = W'(bus.data_in[j*BITS +: BITS]);
                end else begin : g_op
                    localparam int CNT_IN = (NUM + (1 << (l-1)) - 1) >> (l-1);
                    if (2*j + 1 < CNT_IN) begin : g_sum
                        assign nxt[l][j] = node[l-1][2*j] + node[l-1][2*j+1];
                    end else if (2*j < CNT_IN) begin : g_pass
                        assign nxt[l][j] = node[l-1][2*j];
                    end else begin : g_zero
                        assign nxt[l][j] = '0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int l = 0; l <= LVL; l++) begin
                for (int j = 0; j < NUM; j++) begin
                    node[l][j] <= '0;
                end
            end
            tv <= '0;
            tl <= '0;
            tm <= '0;
        end else if (adv) begin
            for (int l = 0; l <= LVL; l++) begin
                for (int j = 0; j < NUM; j++) begin
                    node[l][j] <= nxt[l][j];
                end
            end
            tv <= {tv[LVL-1:0], bus.valid};
            tl <= {tl[LVL-1:0], bus.last};
            tm <= {tm[LVL-1:0], bus.acc_mode};
        end
    end

    always_comb begin
        base    = tm[LVL] ? acc : '0;
        sum     = {1'b0, node[LVL][0]} + (W+1)'(base);
        over    = (sum > MAX_SUM);
        ovf_new = over | (tm[LVL] & ovf_st);
        emit    = !tm[LVL] || tl[LVL];
        res     = sum[BITS-1:0];
`ifdef ADDER_SAT_EN
        if (over) begin
            res = '1;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc         <= '0;
            ovf_st      <= 1'b0;
            o_r         <= '0;
            ovf_r       <= 1'b0;
            valid_out_r <= 1'b0;
        end else if (adv) begin
            if (tv[LVL]) begin
                if (emit) begin
                    o_r         <= res;
                    ovf_r       <= ovf_new;
                    valid_out_r <= 1'b1;
                    acc         <= '0;
                    ovf_st      <= 1'b0;
                end else begin
                    acc         <= res;
                    ovf_st      <= ovf_new;
                    valid_out_r <= 1'b0;
                end
            end else begin
                valid_out_r <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adder_tree_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_acc
// Brief    : Randomised self-checking bench for adder_tree_acc (NUM=4 and 5).
// Revision : 1.0
// ============================================================================
module tb_adder_tree_acc;
    localparam int BITS = 16;
    localparam int NUM  = 4;
    localparam int NUM5 = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    adder_tree_acc_if #(.BITS(BITS), .NUM(NUM))  bus ();
    adder_tree_acc_if #(.BITS(BITS), .NUM(NUM5)) bus5 ();

    adder_tree_acc #(.BITS(BITS), .NUM(NUM))  dut  (.clk(clk), .resetn(resetn), .bus(bus.slave));
    adder_tree_acc #(.BITS(BITS), .NUM(NUM5)) dut5 (.clk(clk), .resetn(resetn), .bus(bus5.slave));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] exp_q [$];
    logic [15:0] m_acc;
    logic        m_ovf;
    bit          mon_en = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_o;
    logic        prev_ovf;
    bit          rnd_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-beat arithmetic applied in acceptance order.
    task automatic model_accept(input logic [63:0] d, input logic am, input logic lst);
        int unsigned ts;
        int unsigned s;
        logic        ov;
        logic        of;
        logic [15:0] r;
        ts = 0;
        for (int i = 0; i < NUM; i++) ts += d[i*BITS +: BITS];
        s  = (am ? m_acc : 0) + ts;
        ov = (s > 65535);
        of = ov || (am && m_ovf);
`ifdef ADDER_SAT_EN
        r  = ov ? 16'hFFFF : s[15:0];
`else
        r  = s[15:0];
`endif
        if (!am || lst) begin
            exp_q.push_back({of, r});
            m_acc = '0;
            m_ovf = 1'b0;
        end else begin
            m_acc = r;
            m_ovf = of;
        end
    endtask

    task automatic send(input logic [63:0] d, input logic am, input logic lst);
        bit ok;
        int guard;
        bus.valid    = 1'b1;
        bus.data_in  = d;
        bus.acc_mode = am;
        bus.last     = lst;
        ok = 0;
        guard = 0;
        while (!ok && guard < 200) begin
            @(negedge clk);
            ok = bus.ready;
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("send_accept", 32'(ok), 1);
        if (ok) model_accept(d, am, lst);
        bus.valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        repeat (8) @(posedge clk);
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check_eq("drain", 32'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && resetn) begin
            if (prev_stall) begin
                check_eq("hold_valid", 32'(bus.valid_out), 1);
                check_eq("hold_o", 32'(bus.o), 32'(prev_o));
                check_eq("hold_ovf", 32'(bus.ovf), 32'(prev_ovf));
            end
            if (bus.valid_out && bus.ready_out) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 32'(exp_q.size() > 0), 1);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check_eq("o", 32'(bus.o), 32'(e[15:0]));
                    check_eq("ovf", 32'(bus.ovf), 32'(e[16]));
                end
            end
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_o     = bus.o;
            prev_ovf   = bus.ovf;
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        int cnt;
        logic [63:0] d;
        logic [63:0] ones;
        ones = {16'd1, 16'd1, 16'd1, 16'd1};
        bus.valid = 0; bus.data_in = '0; bus.last = 0; bus.acc_mode = 0; bus.ready_out = 1;
        bus5.valid = 0; bus5.data_in = '0; bus5.last = 0; bus5.acc_mode = 0; bus5.ready_out = 1;
        m_acc = '0;
        m_ovf = 1'b0;
        mon_en = 1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_o", 32'(bus.o), 0);
        check_eq("rst_ovf", 32'(bus.ovf), 0);
        check_eq("rst_valid_out", 32'(bus.valid_out), 0);
        check_eq("rst_ready", 32'(bus.ready), 1);
        check_eq("rst5_valid_out", 32'(bus5.valid_out), 0);
        resetn = 1;
        @(posedge clk);
        #1;

        // Single beat: latency and one-cycle result pulse.
        send({16'd4, 16'd3, 16'd2, 16'd1}, 0, 0);
        cnt = 0;
        while (!bus.valid_out && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_eq("latency4", 32'(cnt), 3);
        check_eq("single_o", 32'(bus.o), 10);
        @(posedge clk);
        #1;
        check_eq("pulse_once", 32'(bus.valid_out), 0);
        drain();

        send(ones, 1, 0);
        send(ones, 1, 0);
        send(ones, 1, 1);
        drain();

        send({16'd0, 16'd0, 16'd1, 16'hFFFF}, 0, 0);
        send({16'd0, 16'd0, 16'd0, 16'd2}, 0, 0);
        drain();

        // Back-to-back beats with a five-cycle consumer stall.
        fork
            begin
                send({16'd4, 16'd3, 16'd2, 16'd1}, 0, 0);
                send({16'd8, 16'd6, 16'd4, 16'd2}, 0, 0);
                send({16'd12, 16'd9, 16'd6, 16'd3}, 0, 0);
                send({16'd16, 16'd12, 16'd8, 16'd4}, 0, 0);
            end
            begin
                int g;
                g = 0;
                while (!bus.valid_out && g < 20) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                bus.ready_out = 0;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("stall_ready", 32'(bus.ready), 0);
                    @(posedge clk);
                    #1;
                end
                bus.ready_out = 1;
            end
        join
        drain();

        // Reset in the middle of an accumulation.
        send(ones, 1, 0);
        send(ones, 1, 0);
        @(posedge clk);
        #1;
        resetn = 0;
        exp_q.delete();
        m_acc = '0;
        m_ovf = 1'b0;
        #2;
        check_eq("midrst_valid_out", 32'(bus.valid_out), 0);
        check_eq("midrst_o", 32'(bus.o), 0);
        @(posedge clk);
        #1;
        resetn = 1;
        send({16'd0, 16'd0, 16'd0, 16'd5}, 0, 0);
        drain();

        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    d = {$urandom, $urandom};
                    if ($urandom_range(0, 1) == 0) d = d & 64'h0FFF_0FFF_0FFF_0FFF;
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.ready_out = ($urandom_range(0, 3) != 0);
                end
                bus.ready_out = 1;
            end
        join
        drain();

        // Five channels: one extra tree level.
        bus5.data_in  = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        bus5.acc_mode = 0;
        bus5.valid    = 1;
        @(negedge clk);
        check_eq("num5_ready", 32'(bus5.ready), 1);
        @(posedge clk);
        #1;
        bus5.valid = 0;
        cnt = 0;
        while (!bus5.valid_out && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_eq("latency5", 32'(cnt), 4);
        check_eq("num5_o", 32'(bus5.o), 15);
        check_eq("num5_ovf", 32'(bus5.ovf), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
